// File: rtl/uart_alu_cmd_seq.sv
// Command sequencer: assembles checked 5-byte UART request frames, launches one
// ALU operation, and streams the 5-byte response frame to the UART transmitter.
module uart_alu_cmd_seq #(
  parameter logic [7:0] HDR_REQ  = 8'hA5,
  parameter logic [7:0] HDR_RSP  = 8'h5A,
  parameter int         BYTE_TMO = 37500,
  parameter int         ALU_TMO  = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  rx_value,
  input  logic        rx_valid,
  output logic [3:0]  alu_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic        alu_start,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic        busy,
  output logic        frame_err
);
  localparam int BW = $clog2(BYTE_TMO + 1);
  localparam int WW = $clog2(ALU_TMO + 1);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_GET_OP   = 4'd1;
  localparam logic [3:0] S_GET_A    = 4'd2;
  localparam logic [3:0] S_GET_B    = 4'd3;
  localparam logic [3:0] S_GET_CHK  = 4'd4;
  localparam logic [3:0] S_EXEC     = 4'd5;
  localparam logic [3:0] S_WAIT     = 4'd6;
  localparam logic [3:0] S_SEND     = 4'd7;
  localparam logic [3:0] S_SEND_GAP = 4'd8;

  function automatic logic [7:0] xor3(input logic [7:0] x, input logic [7:0] y,
                                      input logic [7:0] z);
    return x ^ y ^ z;
  endfunction

  function automatic logic [7:0] rsp_byte(input logic [2:0] idx, input logic [15:0] res,
                                          input logic [7:0] st);
    case (idx)
      3'd0:    rsp_byte = HDR_RSP;
      3'd1:    rsp_byte = res[15:8];
      3'd2:    rsp_byte = res[7:0];
      3'd3:    rsp_byte = st;
      default: rsp_byte = xor3(res[15:8], res[7:0], st);
    endcase
  endfunction

  logic [3:0]    state_q, state_d;
  logic [BW-1:0] byte_cnt_q, byte_cnt_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic [7:0]    op_q, op_d, a_q, a_d, b_q, b_d;
  logic [3:0]    alu_op_q, alu_op_d;
  logic [7:0]    alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic          alu_start_q, alu_start_d;
  logic [15:0]   res_q, res_d;
  logic [7:0]    status_q, status_d;
  logic [2:0]    idx_q, idx_d;
  logic          gap_seen_q, gap_seen_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_start_q, tx_start_d;
  logic          busy_q, busy_d;
  logic          frame_err_q, frame_err_d;
  logic          byte_tmo_s;

  assign byte_tmo_s = (byte_cnt_q == BW'(BYTE_TMO));

  // Next-state and datapath decode for the whole request/response sequence.
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = '0;
    wait_cnt_d  = '0;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    alu_op_d    = alu_op_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_start_d = 1'b0;
    res_d       = res_q;
    status_d    = status_q;
    idx_d       = idx_q;
    gap_seen_d  = gap_seen_q;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rx_valid && (rx_value == HDR_REQ)) begin
          state_d = S_GET_OP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GET_OP, S_GET_A, S_GET_B: begin
        if (rx_valid) begin
          if (state_q == S_GET_OP) begin
            op_d = rx_value;
          end else if (state_q == S_GET_A) begin
            a_d = rx_value;
          end else begin
            b_d = rx_value;
          end
          state_d = state_q + 4'd1;
        end else if (byte_tmo_s) begin
          frame_err_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          byte_cnt_d = byte_cnt_q + BW'(1);
        end
      end
      S_GET_CHK: begin
        if (rx_valid) begin
          if ((rx_value != xor3(op_q, a_q, b_q)) || (op_q[7:4] != 4'h0)) begin
            frame_err_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            alu_op_d = op_q[3:0];
            alu_a_d  = a_q;
            alu_b_d  = b_q;
            state_d  = S_EXEC;
          end
        end else if (byte_tmo_s) begin
          frame_err_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          byte_cnt_d = byte_cnt_q + BW'(1);
        end
      end
      S_EXEC: begin
        alu_start_d = 1'b1;
        state_d     = S_WAIT;
      end
      // A done arriving in the timeout cycle still delivers the real result.
      S_WAIT: begin
        if (alu_done) begin
          res_d    = alu_result;
          status_d = 8'h00;
          idx_d    = 3'd0;
          state_d  = S_SEND;
        end else if (wait_cnt_q == WW'(ALU_TMO)) begin
          res_d    = 16'hFFFF;
          status_d = 8'hEE;
          idx_d    = 3'd0;
          state_d  = S_SEND;
        end else begin
          wait_cnt_d = wait_cnt_q + WW'(1);
        end
      end
      S_SEND: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = rsp_byte(idx_q, res_q, status_q);
          gap_seen_d = 1'b0;
          state_d    = S_SEND_GAP;
        end else begin
          state_d = S_SEND;
        end
      end
      // First gap cycle ignores tx_busy, which may not have risen yet.
      S_SEND_GAP: begin
        if (!gap_seen_q) begin
          gap_seen_d = 1'b1;
        end else if (!tx_busy) begin
          if (idx_q == 3'd4) begin
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = S_SEND;
          end
        end else begin
          state_d = S_SEND_GAP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      byte_cnt_q  <= '0;
      wait_cnt_q  <= '0;
      op_q        <= 8'h00;
      a_q         <= 8'h00;
      b_q         <= 8'h00;
      alu_op_q    <= 4'h0;
      alu_a_q     <= 8'h00;
      alu_b_q     <= 8'h00;
      alu_start_q <= 1'b0;
      res_q       <= 16'h0000;
      status_q    <= 8'h00;
      idx_q       <= 3'd0;
      gap_seen_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      tx_start_q  <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      alu_op_q    <= alu_op_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_start_q <= alu_start_d;
      res_q       <= res_d;
      status_q    <= status_d;
      idx_q       <= idx_d;
      gap_seen_q  <= gap_seen_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign alu_op    = alu_op_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_start = alu_start_q;
  assign tx_data   = tx_data_q;
  assign tx_start  = tx_start_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_alu_cmd_seq.sv
// Bench for uart_alu_cmd_seq: table vectors, hand-written corner sequences and
// random frames checked against a frame-level reference model.
module tb_uart_alu_cmd_seq;
  localparam int BYTE_TMO = 37500;
  localparam int ALU_TMO  = 255;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_value = 8'h00;
  logic        rx_valid = 1'b0;
  logic [3:0]  alu_op;
  logic [7:0]  alu_a, alu_b, tx_data;
  logic        alu_start, tx_start, busy, frame_err;
  logic        alu_done = 1'b0;
  logic [15:0] alu_result = 16'h0000;
  logic        tx_busy = 1'b0;

  uart_alu_cmd_seq dut (
    .clock(clock), .reset(reset), .rx_value(rx_value), .rx_valid(rx_valid),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_start(alu_start),
    .alu_done(alu_done), .alu_result(alu_result), .tx_data(tx_data),
    .tx_start(tx_start), .tx_busy(tx_busy), .busy(busy), .frame_err(frame_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0][7:0] b;      // b[4]=header .. b[0]=chk
    int              dly;    // ALU done delay after alu_start, -1 = never
    int              exp_err;
    int              exp_start;
    logic [15:0]     exp_res;
    logic [7:0]      exp_st;
    bit              junk;   // send a stray header byte while the command runs
  } vec_t;

  int n_checks = 0, n_errors = 0;
  int cyc = 0, last_rx_cyc = 0, gap = 0;
  int n_err = 0, n_start = 0, err_cyc = 0, start_cyc = 0, done_cyc = 0;
  int overlap = 0, proto_bad = 0, stable_bad = 0;
  logic [3:0] cap_op = 4'h0;
  logic [7:0] cap_a = 8'h00, cap_b = 8'h00, last_tx = 8'h00;
  logic [7:0] txlog[$];
  int         txcyc[$];
  int  alu_delay = 0, due = 0, tx_len = 3, busy_left = 0;
  bit  pend = 1'b0, force_busy = 1'b0;
  vec_t vecs[7];

  function automatic logic [15:0] tb_alu(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    if (op == 4'd1) return 16'(a) + 16'(b);
    return 16'(a) * 16'(b) + 16'(op);
  endfunction

  function automatic vec_t mk(input logic [39:0] b, input int dly, input int ee, input int es,
                              input logic [15:0] r, input logic [7:0] st, input bit junk);
    vec_t v;
    v.b = b; v.dly = dly; v.exp_err = ee; v.exp_start = es;
    v.exp_res = r; v.exp_st = st; v.junk = junk;
    return v;
  endfunction

  always @(posedge clock) cyc <= cyc + 1;

  // ALU responder, transmitter model and event monitor, all at the falling edge.
  always @(negedge clock) begin
    if (!reset) begin
      pend = 1'b0; alu_done = 1'b0; busy_left = 0; tx_busy = 1'b0;
    end else begin
      if (frame_err) begin n_err++; err_cyc = cyc; end
      if (frame_err && alu_start) overlap++;
      if (alu_start) begin
        n_start++; start_cyc = cyc;
        cap_op = alu_op; cap_a = alu_a; cap_b = alu_b;
        if (alu_delay >= 0) begin pend = 1'b1; due = cyc + alu_delay; end
      end
      alu_done = 1'b0;
      if (pend && cyc == due) begin
        alu_done = 1'b1; alu_result = tb_alu(cap_op, cap_a, cap_b);
        done_cyc = cyc; pend = 1'b0;
      end
      if (tx_busy && !tx_start && tx_data != last_tx) stable_bad++;
      if (tx_start) begin
        if (tx_busy) proto_bad++;
        txlog.push_back(tx_data); txcyc.push_back(cyc);
        last_tx = tx_data; busy_left = tx_len;
      end else if (busy_left > 0) begin
        busy_left--;
      end
      tx_busy = (busy_left > 0) || force_busy;
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clock);
    rx_value = b; rx_valid = 1'b1; last_rx_cyc = cyc;
    @(negedge clock);
    rx_valid = 1'b0; rx_value = 8'h00;
    repeat (gap) @(negedge clock);
  endtask

  task automatic wait_idle();
    int n = 0;
    repeat (3) @(negedge clock);
    while ((busy || tx_busy || pend) && n < 3000) begin @(negedge clock); n++; end
    check("idle_reached", int'(n < 3000), 1);
  endtask

  task automatic check_tx(input int t0, input logic [15:0] r, input logic [7:0] st);
    logic [7:0] exp_b [5];
    exp_b[0] = 8'h5A; exp_b[1] = r[15:8]; exp_b[2] = r[7:0]; exp_b[3] = st;
    exp_b[4] = r[15:8] ^ r[7:0] ^ st;
    check("tx_count", txlog.size() - t0, 5);
    for (int i = 0; i < 5; i++)
      if (t0 + i < txlog.size()) check($sformatf("tx_byte%0d", i), int'(txlog[t0+i]), int'(exp_b[i]));
  endtask

  task automatic run_vec(input vec_t v);
    int e0, s0, t0, ov0, pb0, sb0, lr, d;
    e0 = n_err; s0 = n_start; t0 = txlog.size();
    ov0 = overlap; pb0 = proto_bad; sb0 = stable_bad;
    alu_delay = v.dly;
    for (int i = 4; i >= 0; i--) send_byte(v.b[i]);
    lr = last_rx_cyc;
    if (v.junk && v.exp_start == 1) send_byte(8'hA5);
    wait_idle();
    check("frame_err_cnt", n_err - e0, v.exp_err);
    check("alu_start_cnt", n_start - s0, v.exp_start);
    if (v.exp_start == 1) begin
      check("alu_op", int'(cap_op), int'(v.b[3][3:0]));
      check("alu_a", int'(cap_a), int'(v.b[2]));
      check("alu_b", int'(cap_b), int'(v.b[1]));
      check("start_latency", start_cyc - lr, 2);
      check_tx(t0, v.exp_res, v.exp_st);
      if (txlog.size() > t0) begin
        d = txcyc[t0] - (v.dly >= 0 ? done_cyc : start_cyc);
        if (v.dly >= 0) check("done_to_tx_latency", d, 2);
        else check("alu_tmo_window", int'(d >= ALU_TMO && d <= ALU_TMO + 3), 1);
      end
    end else begin
      check("tx_count", txlog.size() - t0, 0);
    end
    check("busy_after", int'(busy), 0);
    check("err_start_overlap", overlap - ov0, 0);
    check("tx_start_while_busy", proto_bad - pb0, 0);
    check("tx_data_stable", stable_bad - sb0, 0);
  endtask

  task automatic reset_check();
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("outputs_in_reset",
          int'({alu_op, alu_a, alu_b, alu_start, tx_data, tx_start, busy, frame_err}), 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    int e0, t0, n, lr;
    logic [7:0] op, a, b, chk;
    bit ok_chk;
    vec_t rv;

    vecs[0] = mk(40'hA5_01_12_34_27, 3, 0, 1, 16'h0046, 8'h00, 1'b0);
    vecs[1] = mk(40'hA5_01_12_34_00, 3, 1, 0, 16'h0000, 8'h00, 1'b0);
    vecs[2] = mk(40'hA5_13_05_06_10, 3, 1, 0, 16'h0000, 8'h00, 1'b0);
    vecs[3] = mk(40'hA5_02_10_20_32, -1, 0, 1, 16'hFFFF, 8'hEE, 1'b0);
    vecs[4] = mk(40'hA5_03_07_09_0D, ALU_TMO, 0, 1, 16'h0042, 8'h00, 1'b0);
    vecs[5] = mk(40'hA5_00_FF_01_FE, 0, 0, 1, 16'h00FF, 8'h00, 1'b0);
    vecs[6] = mk(40'hA5_0F_80_80_0F, 7, 0, 1, 16'h400F, 8'h00, 1'b1);

    repeat (3) @(negedge clock);
    #1;
    check("reset_state",
          int'({alu_op, alu_a, alu_b, alu_start, tx_data, tx_start, busy, frame_err}), 0);
    reset = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Inter-byte timeout, then a normal frame.
    e0 = n_err; gap = 0;
    send_byte(8'hA5); send_byte(8'h02);
    lr = last_rx_cyc; n = 0;
    while (n_err == e0 && n < BYTE_TMO + 50) begin @(negedge clock); n++; end
    check("byte_tmo_err", n_err - e0, 1);
    check("byte_tmo_window", int'(err_cyc - lr >= BYTE_TMO && err_cyc - lr <= BYTE_TMO + 3), 1);
    repeat (2) @(negedge clock);
    check("byte_tmo_busy", int'(busy), 0);
    run_vec(vecs[0]);

    // Noise before header, then transmitter held busy mid-response.
    e0 = n_err;
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h3C);
    repeat (2) @(negedge clock);
    check("noise_no_err", n_err - e0, 0);
    check("noise_idle", int'(busy), 0);
    t0 = txlog.size(); alu_delay = 2;
    for (int i = 4; i >= 0; i--) send_byte(vecs[0].b[i]);
    n = 0;
    while (txlog.size() - t0 < 2 && n < 500) begin @(negedge clock); n++; end
    force_busy = 1'b1;
    repeat (100) @(negedge clock);
    check("held_tx_count", txlog.size() - t0, 2);
    force_busy = 1'b0;
    wait_idle();
    check_tx(t0, 16'h0046, 8'h00);
    check("hold_proto", proto_bad, 0);

    // Reset while waiting on the ALU.
    alu_delay = -1; n = 0; e0 = n_start;
    for (int i = 4; i >= 0; i--) send_byte(vecs[0].b[i]);
    while (n_start == e0 && n < 50) begin @(negedge clock); n++; end
    repeat (10) @(negedge clock);
    check("busy_in_wait", int'(busy), 1);
    reset_check();
    run_vec(vecs[5]);

    // Reset while stalled in the send gap.
    tx_len = 60; alu_delay = 0; t0 = txlog.size(); n = 0;
    for (int i = 4; i >= 0; i--) send_byte(vecs[6].b[i]);
    while (txlog.size() == t0 && n < 100) begin @(negedge clock); n++; end
    repeat (5) @(negedge clock);
    check("busy_in_gap", int'(busy), 1);
    reset_check();
    tx_len = 3;
    run_vec(vecs[0]);

    // Random frames against the frame-level model.
    for (int k = 0; k < 40; k++) begin
      op = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      a = 8'($urandom); b = 8'($urandom);
      ok_chk = ($urandom_range(0, 4) != 0);
      chk = op ^ a ^ b ^ (ok_chk ? 8'h00 : 8'($urandom_range(1, 255)));
      gap = $urandom_range(0, 3);
      tx_len = $urandom_range(1, 8);
      rv.b = {8'hA5, op, a, b, chk};
      rv.dly = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 20);
      rv.junk = $urandom_range(0, 1) == 1;
      if (ok_chk && op[7:4] == 4'h0) begin
        rv.exp_err = 0; rv.exp_start = 1;
        rv.exp_res = (rv.dly < 0) ? 16'hFFFF : tb_alu(op[3:0], a, b);
        rv.exp_st = (rv.dly < 0) ? 8'hEE : 8'h00;
      end else begin
        rv.exp_err = 1; rv.exp_start = 0; rv.exp_res = 16'h0000; rv.exp_st = 8'h00;
      end
      run_vec(rv);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
